// File: rtl/fip_sqrt_iter.sv
// Iterative fixed-point square root: restoring digit-by-digit over {rad, FRA_BITS zeros},
// IPC root bits per clock, optional round-to-nearest, busy/valid/ready result handshake.
module fip_sqrt_iter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned FRA_BITS = 16,
    parameter int unsigned IPC      = 1,
    parameter int unsigned ROUND    = 0,
    parameter int unsigned TAG_W    = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic [WIDTH-1:0]   i_rad,
    input  logic [TAG_W-1:0]   i_tag,
    input  logic               i_ready,
    output logic               o_busy,
    output logic               o_valid,
    output logic [WIDTH-1:0]   o_root,
    output logic [TAG_W-1:0]   o_tag
);

    localparam int unsigned N_BITS = WIDTH + FRA_BITS;
    localparam int unsigned ITERS  = N_BITS / 2;
    localparam int unsigned STEPS  = ITERS / IPC;
    localparam int unsigned CNT_W  = $clog2(STEPS + 1);
    localparam int unsigned OUT_W  = WIDTH + 1;

    if ((N_BITS % 2) != 0) begin : g_err_odd
        $error("fip_sqrt_iter: WIDTH+FRA_BITS must be even");
    end
    if ((IPC == 0) || ((ITERS % IPC) != 0)) begin : g_err_ipc
        $error("fip_sqrt_iter: ITERS must be a nonzero multiple of IPC");
    end
    if (FRA_BITS > WIDTH) begin : g_err_fra
        $error("fip_sqrt_iter: FRA_BITS must not exceed WIDTH");
    end

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_BITS-1:0]   rad_q, rad_d, step_rad;
    logic [ITERS+1:0]    rem_q, rem_d, step_rem, trial;
    logic [ITERS-1:0]    root_q, root_d, step_root;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [WIDTH-1:0]    out_q, out_d, final_root;
    logic [OUT_W-1:0]    rnd_sum;
    logic                rnd_up;

    // IPC restoring steps chained within one cycle, then optional rounding of the result.
    always_comb begin
        step_rad  = rad_q;
        step_rem  = rem_q;
        step_root = root_q;
        trial     = '0;
        for (int unsigned i = 0; i < IPC; i++) begin
            step_rem = {step_rem[ITERS-1:0], step_rad[N_BITS-1 -: 2]};
            trial    = {step_root, 2'b01};
            if (step_rem >= trial) begin
                step_rem  = step_rem - trial;
                step_root = (step_root << 1) | ITERS'(1);
            end else begin
                step_root = step_root << 1;
            end
            step_rad = step_rad << 2;
        end
        // Remainder above the root means sqrt lies at or past root + 0.5.
        rnd_up     = (ROUND != 0) && (step_rem > {2'b00, step_root});
        rnd_sum    = OUT_W'(step_root) + OUT_W'(rnd_up);
        final_root = rnd_sum[WIDTH] ? '1 : rnd_sum[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rad_d   = rad_q;
        rem_d   = rem_q;
        root_d  = root_q;
        tag_d   = tag_q;
        out_d   = out_q;
        unique case (state_q)
            StIdle: begin
                if (i_en) begin
                    rad_d   = N_BITS'(i_rad) << FRA_BITS;
                    rem_d   = '0;
                    root_d  = '0;
                    tag_d   = i_tag;
                    cnt_d   = CNT_W'(STEPS);
                    state_d = StCalc;
                end
            end
            StCalc: begin
                rad_d  = step_rad;
                rem_d  = step_rem;
                root_d = step_root;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    out_d   = final_root;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            tag_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            tag_q   <= tag_d;
            out_q   <= out_d;
        end
    end

    assign o_busy  = (state_q != StIdle);
    assign o_valid = (state_q == StDone);
    assign o_root  = out_q;
    assign o_tag   = tag_q;

endmodule

// File: tb/tb_fip_sqrt_iter.sv
// Bench for fip_sqrt_iter: eight IPC/ROUND sweep lanes plus one default lane for directed
// handshake, backpressure and reset cases; per-lane scoreboard queues checked by monitors.
module tb_fip_sqrt_iter;

    localparam int NL    = 9;
    localparam int NS    = 8;
    localparam int MAIN  = 8;
    localparam int NRAND = 1000;
    localparam int NCORN = 6;

    typedef struct packed {
        logic [31:0] root;
        logic [3:0]  tag;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic        rst_s = 1'b1;
    logic        rst_m = 1'b1;
    logic        m_en = 1'b0;
    logic        m_ready = 1'b1;
    logic [31:0] m_rad = '0;
    logic [3:0]  m_tag = '0;

    exp_t exp_q [NL][$];

    logic [31:0] c_rad [NCORN] = '{32'h0004_0000, 32'h0, 32'h0002_0000, 32'hFFFF_FFFF,
                                   32'h0000_0001, 32'h0001_0000};
    logic [31:0] c_flr [NCORN] = '{32'h0002_0000, 32'h0, 32'h0001_6A09, 32'h00FF_FFFF,
                                   32'h0000_0100, 32'h0001_0000};
    logic [31:0] c_rnd [NCORN] = '{32'h0002_0000, 32'h0, 32'h0001_6A0A, 32'h0100_0000,
                                   32'h0000_0100, 32'h0001_0000};

    task automatic chk(input string name, input int lane, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s lane %0d: got %0h want %0h", name, lane, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // floor(sqrt(x * 2^16)) by binary search; rounding picks r+1 when (2r+1)^2 <= 4X.
    function automatic logic [31:0] ref_sqrt(input logic [31:0] x, input bit rnd);
        longint unsigned big, lo, hi, mid;
        big = 64'(x) << 16;
        lo  = 0;
        hi  = 64'd1 << 25;
        while (lo < hi) begin
            mid = (lo + hi + 1) >> 1;
            if (mid * mid <= big) lo = mid;
            else hi = mid - 1;
        end
        if (rnd && (4 * big >= (2 * lo + 1) * (2 * lo + 1))) lo = lo + 1;
        if (lo > 64'hFFFF_FFFF) return '1;
        return lo[31:0];
    endfunction

    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int unsigned LIPC = (g == MAIN) ? 1 : (1 << (g / 2));
        localparam int unsigned LRND = (g == MAIN) ? 0 : (g % 2);
        localparam int          LAT  = 24 / int'(LIPC) + 1;

        logic        lrst, en, ready, busy, valid;
        logic [31:0] rad, root;
        logic [3:0]  tag, otag;

        fip_sqrt_iter #(
            .WIDTH   (32),
            .FRA_BITS(16),
            .IPC     (LIPC),
            .ROUND   (LRND),
            .TAG_W   (4)
        ) u_dut (
            .i_clk  (clk),
            .i_rst  (lrst),
            .i_en   (en),
            .i_rad  (rad),
            .i_tag  (tag),
            .i_ready(ready),
            .o_busy (busy),
            .o_valid(valid),
            .o_root (root),
            .o_tag  (otag)
        );

        initial begin
            exp_t cur;
            logic pv, phs;
            pv  = 1'b0;
            phs = 1'b0;
            cur = '0;
            forever begin
                @(negedge clk);
                if (lrst !== 1'b0) begin
                    pv  = 1'b0;
                    phs = 1'b0;
                end else begin
                    if (phs) chk("valid_drop", g, 64'(valid), 64'd0);
                    if (valid && !pv) begin
                        if (exp_q[g].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_valid lane %0d: got valid with root %0h, want no result",
                                     g, root);
                        end else begin
                            cur = exp_q[g].pop_front();
                            chk("root", g, 64'(root), 64'(cur.root));
                            chk("tag", g, 64'(otag), 64'(cur.tag));
                            chk("latency", g, 64'(cyc - cur.acc), 64'(cur.lat));
                        end
                    end else if (valid && pv) begin
                        chk("hold_root", g, 64'(root), 64'(cur.root));
                        chk("hold_tag", g, 64'(otag), 64'(cur.tag));
                    end
                    if (valid) chk("busy_in_done", g, 64'(busy), 64'd1);
                    pv  = valid;
                    phs = valid && ready;
                end
            end
        end

        if (g == MAIN) begin : g_m
            assign lrst  = rst_m;
            assign en    = m_en;
            assign rad   = m_rad;
            assign tag   = m_tag;
            assign ready = m_ready;
        end else begin : g_s
            assign lrst = rst_s;

            initial begin
                ready = 1'b1;
                wait (rst_s == 1'b0);
                forever begin
                    tick();
                    ready = ($urandom_range(3) != 0);
                end
            end

            initial begin
                int          issued;
                exp_t        e;
                logic [31:0] x;
                issued = 0;
                en     = 1'b0;
                rad    = '0;
                tag    = '0;
                wait (rst_s == 1'b0);
                while (issued < NCORN + NRAND) begin
                    tick();
                    if (!busy && ($urandom_range(2) != 0)) begin
                        if (issued < NCORN) begin
                            x      = c_rad[issued];
                            e.root = (LRND != 0) ? c_rnd[issued] : c_flr[issued];
                        end else begin
                            case ($urandom_range(3))
                                0:       x = $urandom;
                                1:       x = 32'($urandom_range(65535));
                                2:       x = 32'hFFFF_0000 | 32'($urandom_range(65535));
                                default: x = $urandom >> $urandom_range(31);
                            endcase
                            e.root = ref_sqrt(x, LRND != 0);
                        end
                        en    = 1'b1;
                        rad   = x;
                        tag   = 4'($urandom);
                        e.tag = tag;
                        e.acc = cyc;
                        e.lat = LAT;
                        exp_q[g].push_back(e);
                        issued++;
                    end else begin
                        // Requests while busy must be ignored.
                        en  = busy && ($urandom_range(3) == 0);
                        rad = $urandom;
                        tag = 4'($urandom);
                    end
                end
                tick();
                en = 1'b0;
                for (int w = 0; w < 400 && exp_q[g].size() != 0; w++) tick();
                done_cnt++;
            end
        end
    end

    task automatic m_issue(input logic [31:0] x, input logic [3:0] t, input logic [31:0] want,
                           input bit push);
        exp_t e;
        int   w;
        w = 0;
        while (g_lane[MAIN].busy && w < 200) begin
            tick();
            w++;
        end
        if (w >= 200) begin
            checks++;
            errors++;
            $display("FAIL issue_wait lane %0d: got busy for %0d cycles, want idle", MAIN, w);
        end
        m_en  = 1'b1;
        m_rad = x;
        m_tag = t;
        if (push) begin
            e.root = want;
            e.tag  = t;
            e.acc  = cyc;
            e.lat  = 25;
            exp_q[MAIN].push_back(e);
        end
        tick();
        m_en = 1'b0;
    endtask

    task automatic m_drain();
        int w;
        w = 0;
        while ((exp_q[MAIN].size() != 0 || g_lane[MAIN].valid) && w < 100) begin
            tick();
            w++;
        end
        if (w >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain_wait lane %0d: got %0d pending, want 0", MAIN, exp_q[MAIN].size());
        end
    endtask

    initial begin
        int w;
        int seen;
        tick();
        tick();
        @(negedge clk);
        chk("rst_busy", MAIN, 64'(g_lane[MAIN].busy), 64'd0);
        chk("rst_valid", MAIN, 64'(g_lane[MAIN].valid), 64'd0);
        chk("rst_root", MAIN, 64'(g_lane[MAIN].root), 64'd0);
        chk("rst_tag", MAIN, 64'(g_lane[MAIN].otag), 64'd0);
        tick();
        rst_s = 1'b0;
        rst_m = 1'b0;
        tick();

        m_issue(32'h0004_0000, 4'd3, 32'h0002_0000, 1'b1);
        m_drain();
        m_issue(32'h0000_0000, 4'd5, 32'h0000_0000, 1'b1);
        m_drain();

        // Backpressure with spurious requests during CALC and DONE.
        m_ready = 1'b0;
        m_issue(32'h0002_0000, 4'd9, 32'h0001_6A09, 1'b1);
        m_en  = 1'b1;
        m_rad = 32'hDEAD_0000;
        m_tag = 4'd15;
        w = 0;
        while (!g_lane[MAIN].valid && w < 100) begin
            tick();
            w++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", MAIN, 64'(g_lane[MAIN].valid), 64'd1);
            chk("bp_root", MAIN, 64'(g_lane[MAIN].root), 64'h0001_6A09);
            chk("bp_tag", MAIN, 64'(g_lane[MAIN].otag), 64'd9);
            tick();
        end
        m_ready = 1'b1;
        tick();
        m_en = 1'b0;
        chk("idle_after_hs", MAIN, 64'(g_lane[MAIN].busy), 64'd0);
        m_issue(32'h0001_0000, 4'd2, 32'h0001_0000, 1'b1);
        m_drain();

        // Reset in the middle of CALC discards the operation.
        m_issue(32'h0009_0000, 4'd6, 32'h0, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        rst_m = 1'b1;
        tick();
        rst_m = 1'b0;
        chk("mid_rst_busy", MAIN, 64'(g_lane[MAIN].busy), 64'd0);
        chk("mid_rst_valid", MAIN, 64'(g_lane[MAIN].valid), 64'd0);
        chk("mid_rst_root", MAIN, 64'(g_lane[MAIN].root), 64'd0);
        chk("mid_rst_tag", MAIN, 64'(g_lane[MAIN].otag), 64'd0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (g_lane[MAIN].valid) seen++;
        end
        chk("no_valid_after_rst", MAIN, 64'(seen), 64'd0);
        m_issue(32'h0004_0000, 4'd4, 32'h0002_0000, 1'b1);
        m_drain();

        w = 0;
        while (done_cnt < NS && w < 60000) begin
            tick();
            w++;
        end
        if (done_cnt < NS) begin
            checks++;
            errors++;
            $display("FAIL sweep_timeout: got %0d lanes done, want %0d", done_cnt, NS);
        end
        for (int i = 0; i < NL; i++) chk("leftover", i, 64'(exp_q[i].size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fip_sqrt_iter.md
# fip_sqrt_iter

Iterative, parametrised fixed-point square-root unit for the ray-tracing datapath. It computes floor or rounded sqrt of an unsigned Q(WIDTH-FRA_BITS).FRA_BITS radicand using digit-by-digit (restoring) integer square root. It replaces the empty 32-bit sqrt stub, feeds vector normalisation ahead of the dividers, and uses a busy/valid/ready handshake so downstream stalls are safe.

## Interface
- WIDTH, 32: radicand/root word width in bits.
- FRA_BITS, 16: fractional bits of the input and output format; requires FRA_BITS <= WIDTH.
- IPC, 1: root bits resolved per clock (iterations per cycle); ITERS = (WIDTH+FRA_BITS)/2 must be divisible by IPC.
- ROUND, 0: 0 = truncate (floor); 1 = round to nearest.
- TAG_W, 4: width of the opaque tag carried with each operation.
- Elaboration error if WIDTH+FRA_BITS is odd, ITERS % IPC != 0, or FRA_BITS > WIDTH.
- i_clk  in  1  clock. One clock domain; all state changes on the rising edge.
- i_rst  in  1  reset. Synchronous, active-high.
- i_en  in  1  request. Accepted only when o_busy=0.
- i_rad  in  WIDTH  unsigned radicand, Q(WIDTH-FRA_BITS).FRA_BITS.
- i_tag  in  TAG_W  tag captured on accept.
- i_ready  in  1  downstream accepts result.
- o_busy  out  1  high in CALC and DONE.
- o_valid  out  1  result valid; held until i_ready.
- o_root  out  WIDTH  root, same Q format as i_rad, zero-extended.
- o_tag  out  TAG_W  tag of the current result.

## Operation
- Math: o_root = floor(sqrt(i_rad * 2^FRA_BITS)). The extended radicand R = {i_rad, FRA_BITS'b0} is N = WIDTH+FRA_BITS bits wide. The root has ITERS bits.
- One restoring step per iteration:
  - rem = (rem << 2) | next 2 MSBs of R.
  - trial = (root << 2) | 1.
  - If rem >= trial: rem -= trial and root = (root << 1) | 1. Otherwise root = root << 1.
  - rem is ITERS+2 bits; all compares are unsigned.
- IPC steps are chained combinationally per cycle.
- ROUND=1: after the final step, increment root if rem > root. If the increment overflows WIDTH bits (possible only when FRA_BITS = WIDTH), saturate o_root to all ones.
- FSM has three states: IDLE, CALC, DONE.
  - IDLE: o_busy=0. If i_en=1, load R, clear rem/root, capture i_tag, load the counter with ITERS/IPC, and go to CALC.
  - CALC: perform IPC steps and decrement the counter each cycle. When the counter reaches 1, the last steps plus rounding complete at that edge, o_root is registered, and the FSM goes to DONE.
  - DONE: o_valid=1; o_root and o_tag are held stable. If i_ready=1, go to IDLE.
- i_en while o_busy=1 is ignored; no queueing.
- i_rad = 0 gives o_root = 0, with normal latency (no early-out).
- Reset, any state including mid-CALC: next state IDLE. o_busy=0, o_valid=0, o_root=0, o_tag=0, all internal registers cleared. The in-flight operation is discarded.

## Timing
- Accept edge E0 (IDLE, i_en=1), where K = ITERS/IPC. Steps execute on edges E1..EK. o_valid is high in the cycle after EK, i.e. K+1 cycles after the request cycle.
- Defaults (K=24): o_valid in cycle 25 after the request. With IPC=4: o_valid in cycle 7.
- Handshake completes on an edge where o_valid=1 and i_ready=1. o_valid drops in the next cycle.
- No accept happens in that same cycle, because o_busy is still 1. The earliest next accept is the cycle after the handshake, giving a minimum initiation interval of K+2 cycles.
- i_ready may be held high permanently: DONE then lasts exactly one cycle.
- i_ready low: DONE, o_root and o_tag hold indefinitely with no change.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset and idle: hold i_rst for 2 cycles -> o_busy=0, o_valid=0, o_root=0, o_tag=0. Assert i_rst for 1 cycle at CALC step 10 -> IDLE next cycle, no o_valid ever appears, and a new request afterwards completes normally.
- Exact roots, defaults: i_rad=0x00040000 (4.0), tag 3 -> o_root=0x00020000, o_tag=3, o_valid exactly 25 cycles after the request. i_rad=0 -> 0x00000000.
- Truncation vs rounding: i_rad=0x00020000 (2.0) -> ROUND=0 gives 0x00016A09; ROUND=1 gives 0x00016A0A.
- Extremes: i_rad=0xFFFFFFFF -> ROUND=0 gives 0x00FFFFFF; ROUND=1 gives 0x01000000. i_rad=0x00000001 -> 0x00000100.
- Backpressure and busy: i_ready=0 for 5 cycles in DONE -> outputs stable. Pulse i_en with a different i_rad during CALC and DONE -> ignored. Raise i_ready -> handshake; the next accept is no earlier than the following cycle.
- Parameter sweep: IPC in {1,2,4,8} and ROUND in {0,1}, 1000 random i_rad each. Compare against the reference model floor/round(sqrt(x*2^16)); check latency = ITERS/IPC+1.
